alu_issue_unit: RTL
===================

ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
REQ-001 SHALL have parameter REG_COUNT, default 4, number of 8-bit operand registers; index width 2, other values unsupported.
REQ-002 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have in_valid  input  1, in_ready  output  1  instruction handshake.
REQ-005 SHALL have in_op  input  3  ALU operation; in_rd  input  2  destination and A-source register.
REQ-006 SHALL have in_rs  input  2  B-source register; in_use_imm  input  1  select in_imm for B; in_imm  input  8  immediate.
REQ-007 SHALL have alu_sel  output  3, alu_a  output  8, alu_b  output  8  registered drive to the combinational ALU.
REQ-008 SHALL have alu_c  input  8  ALU result, sampled same cycle as driven.
REQ-009 SHALL have res_valid  output  1, res_data  output  8, res_rd  output  2, res_err  output  1  write-back report.

Function
REQ-010 SHALL implement FSM states IDLE, EXEC, WB; transitions IDLE->EXEC on handshake, EXEC->WB unconditionally, WB->IDLE unconditionally.
REQ-011 SHALL assert in_ready only in IDLE with rst_n high; handshake = in_valid & in_ready at a rising edge.
REQ-012 SHALL, on handshake at edge T, capture op/rd/rs/use_imm/imm and drive during EXEC: alu_sel=op, alu_a=R[rd], alu_b=use_imm ? imm : R[rs].
REQ-013 SHALL, at the edge ending EXEC, write alu_c into R[rd] for legal ops (0 pass B, 1 NOT B, 2 AND, 3 OR, 4 XOR).
REQ-014 SHALL, during WB, hold res_valid=1 for exactly one cycle with res_data=written value, res_rd=rd, res_err=0.
REQ-015 SHALL treat ops 5-7 as illegal: no register write, res_valid=1, res_err=1, res_data=0 in WB.
REQ-016 SHALL give latency 2 cycles (handshake edge to res_valid) and throughput one instruction per 3 cycles.
REQ-017 SHALL hold alu_sel/alu_a/alu_b stable outside EXEC at last driven values; in_valid/in_* changes outside IDLE SHALL be ignored.
REQ-018 SHALL read R[rd]/R[rs] after any write-back of the previous instruction (serial operation, no hazard possible).
REQ-019 SHALL, when rd==rs, use the same register value for both A and B.

Reset
REQ-020 SHALL, while rst_n low, force state IDLE, in_ready=0, R0..R3=0x00, alu_sel=0, alu_a=0, alu_b=0, res_valid=0, res_data=0, res_rd=0, res_err=0.
REQ-021 SHALL, on reset during EXEC or WB, abort the instruction with no register write and no res_valid pulse.
REQ-022 SHALL accept the first instruction no earlier than the first rising edge after rst_n deasserts.

Structure
REQ-023 SHALL place op encodings (OP_PASSB=0, OP_NOT=1, OP_AND=2, OP_OR=3, OP_XOR=4), FSM state encodings and REG_COUNT default in shared package alu_pkg.
REQ-024 SHALL isolate the operand storage as one sub-module regfile_4x8 (two async read ports, one sync write port, async active-low reset).

Verification
REQ-025 Reset: assert rst_n low mid-run -> all outputs per REQ-020 immediately; R0..R3 read back 0x00.
REQ-026 Load: op=0, rd=1, use_imm=1, imm=0xF3 at T -> EXEC alu_b=0xF3; WB res_data=0xF3, res_rd=1; R1=0xF3.
REQ-027 Logic: R1=0xF3, R2=0x25, op=2, rd=1, rs=2 -> 0x21; R1=0x73, imm=0x8B op=3 -> 0xFB; R1=0xA3, imm=0x45 op=4 -> 0xE6; R0=0x00, imm=0x0C op=1 -> 0xF3.
REQ-028 Back-pressure: in_valid held high continuously with two instructions -> second accepted at T+3, in_ready low during EXEC/WB.
REQ-029 Illegal: op=3'b110, rd=2 -> WB res_err=1, res_data=0x00; R2 unchanged.
REQ-030 Abort: rst_n low during EXEC of op=0, rd=3, imm=0x55 -> no res_valid; R3=0x00 after reset release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue unit: operation codes, FSM states and
// register-file geometry.
package alu_pkg;

    localparam int unsigned REG_COUNT_DEFAULT = 4;
    localparam int unsigned ADDR_W            = 2;
    localparam int unsigned DATA_W            = 8;

    typedef enum logic [2:0] {
        OP_PASSB = 3'd0,
        OP_NOT   = 3'd1,
        OP_AND   = 3'd2,
        OP_OR    = 3'd3,
        OP_XOR   = 3'd4
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_e;

    // Encodings above OP_XOR have no defined ALU behaviour.
    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_XOR;
    endfunction

endpackage

// File: rtl/regfile_4x8.sv
// Operand storage: two asynchronous read ports, one synchronous write port,
// asynchronous active-low clear.
module regfile_4x8
    import alu_pkg::*;
#(
    parameter int unsigned REG_COUNT = REG_COUNT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs [REG_COUNT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_a = regs[rd_addr_a];
        rd_data_b = regs[rd_addr_b];
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Serial issue stage: accepts one instruction, drives the external ALU for one
// cycle, writes the result back and reports it during a single WB cycle.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int unsigned REG_COUNT = REG_COUNT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [ADDR_W-1:0] in_rs,
    input  logic              in_use_imm,
    input  logic [DATA_W-1:0] in_imm,
    output logic [2:0]        alu_sel,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_c,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic [ADDR_W-1:0] res_rd,
    output logic              res_err
);

    state_e            state;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              handshake;
    logic              wr_en;
    logic              legal;

    always_comb begin
        in_ready  = rst_n && (state == IDLE);
        handshake = in_valid && in_ready;
        legal     = op_legal(alu_sel);
        wr_en     = (state == EXEC) && legal;
    end

    // Operands are read straight from the instruction fields so they are
    // latched into alu_a/alu_b on the accepting edge.
    regfile_4x8 #(
        .REG_COUNT(REG_COUNT)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (in_rd),
        .rd_data_a (rd_data_a),
        .rd_addr_b (in_rs),
        .rd_data_b (rd_data_b),
        .wr_en     (wr_en),
        .wr_addr   (rd_q),
        .wr_data   (alu_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_q      <= '0;
            alu_sel   <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_rd    <= '0;
            res_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (handshake) begin
                        rd_q    <= in_rd;
                        alu_sel <= in_op;
                        alu_a   <= rd_data_a;
                        alu_b   <= in_use_imm ? in_imm : rd_data_b;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    res_valid <= 1'b1;
                    res_rd    <= rd_q;
                    res_err   <= !legal;
                    res_data  <= legal ? alu_c : '0;
                    state     <= WB;
                end
                WB: begin
                    res_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
